// File: rtl/tune_loader_pkg.sv
// Shared types and constants for the tune_loader command-frame parser.
// Build macro TUNE_LOADER_CKSUM_EN adds a trailing checksum byte (CKS state).
package tune_loader_pkg;

`ifdef TUNE_LOADER_CKSUM_EN
  typedef enum logic [2:0] {IDLE, CMD, LO, HI, CKS, WR_F, WR_R} state_e;
  localparam int FRAME_LEN = 5;
`else
  typedef enum logic [2:0] {IDLE, CMD, LO, HI, WR_F, WR_R} state_e;
  localparam int FRAME_LEN = 4;
`endif

  localparam logic [7:0] DEF_HEADER   = 8'hA5;
  localparam logic [7:0] DEF_CMD_TUNE = 8'h01;
  localparam logic [7:0] DEF_CMD_RUN  = 8'h02;
  localparam logic [7:0] DEF_CMD_HALT = 8'h03;

  function automatic logic [7:0] frame_cks(input logic [7:0] cmd,
                                           input logic [7:0] lo,
                                           input logic [7:0] hi);
    return cmd ^ lo ^ hi;
  endfunction

endpackage

// File: rtl/tune_loader.sv
// Byte-stream frame parser that loads a 16-bit tuning word into a phase accumulator.
// Build macro TUNE_LOADER_CKSUM_EN requires a fifth checksum byte per frame.
module tune_loader
  import tune_loader_pkg::*;
#(
  parameter logic [7:0] HEADER   = DEF_HEADER,
  parameter logic [7:0] CMD_TUNE = DEF_CMD_TUNE,
  parameter logic [7:0] CMD_RUN  = DEF_CMD_RUN,
  parameter logic [7:0] CMD_HALT = DEF_CMD_HALT
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       in_valid,
  input  logic [7:0] in_byte,
  output logic       in_ready,
  output logic [7:0] data,
  output logic       wr_divf,
  output logic       wr_divr,
  output logic       en,
  output logic       busy,
  output logic       err
);

  state_e     r_state, w_state_next;
  logic [7:0] r_cmd, r_lo, r_hi;
  logic       r_en, r_err;
  logic       w_en_next, w_err_next, w_accept, w_eval, w_writing;

  assign w_writing = (r_state == WR_F) || (r_state == WR_R);
  assign in_ready  = !w_writing;
  assign w_accept  = in_valid && in_ready;
  assign busy      = (r_state != IDLE);
  // The accumulator is frozen while its increment is half-written; r_en keeps the pre-frame value.
  assign en        = r_en && !w_writing;
  assign err       = r_err;

  always_comb begin
    // NOTE: every signal driven here gets a default first, so no path can infer a latch.
    w_state_next = r_state;
    w_eval       = 1'b0;
    w_err_next   = 1'b0;
    w_en_next    = r_en;
    data         = '0;
    wr_divf      = 1'b0;
    wr_divr      = 1'b0;

    case (r_state)
      IDLE: if (w_accept && in_byte == HEADER) w_state_next = CMD;
      CMD:  if (w_accept) w_state_next = LO;
      LO:   if (w_accept) w_state_next = HI;
`ifdef TUNE_LOADER_CKSUM_EN
      HI:   if (w_accept) w_state_next = CKS;
      CKS: begin
        if (w_accept) begin
          if (in_byte == frame_cks(r_cmd, r_lo, r_hi)) begin
            w_eval = 1'b1;
          end else begin
            w_err_next   = 1'b1;
            w_state_next = IDLE;
          end
        end
      end
`else
      HI:   if (w_accept) w_eval = 1'b1;
`endif
      WR_F: begin
        data         = r_lo;
        wr_divf      = 1'b1;
        w_state_next = WR_R;
      end
      WR_R: begin
        data         = r_hi;
        wr_divr      = 1'b1;
        w_state_next = IDLE;
      end
      default: w_state_next = IDLE;
    endcase

    // Last byte of a good frame: dispatch on the latched command.
    if (w_eval) begin
      w_state_next = IDLE;
      if (r_cmd == CMD_TUNE)      w_state_next = WR_F;
      else if (r_cmd == CMD_RUN)  w_en_next    = 1'b1;
      else if (r_cmd == CMD_HALT) w_en_next    = 1'b0;
      else                        w_err_next   = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: registers use non-blocking assignments so all of them sample pre-edge values.
    if (rst) begin
      r_state <= IDLE;
      r_en    <= 1'b0;
      r_err   <= 1'b0;
      // NOTE: payload registers are cleared too, so an aborted frame never leaks into a later write.
      r_cmd   <= '0;
      r_lo    <= '0;
      r_hi    <= '0;
    end else begin
      r_state <= w_state_next;
      r_en    <= w_en_next;
      r_err   <= w_err_next;
      if (w_accept) begin
        case (r_state)
          CMD:     r_cmd <= in_byte;
          LO:      r_lo  <= in_byte;
          HI:      r_hi  <= in_byte;
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_tune_loader.sv
// Scoreboard bench for tune_loader: a frame-level model queues timed output events,
// a negedge monitor pops and compares them. Honours TUNE_LOADER_CKSUM_EN.
module tb_tune_loader;
  import tune_loader_pkg::*;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       in_valid = 1'b0;
  logic [7:0] in_byte = 8'h00;
  logic       in_ready, wr_divf, wr_divr, en, busy, err;
  logic [7:0] data;

  tune_loader dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_byte  (in_byte),
    .in_ready (in_ready),
    .data     (data),
    .wr_divf  (wr_divf),
    .wr_divr  (wr_divr),
    .en       (en),
    .busy     (busy),
    .err      (err)
  );

  always #5 clk = ~clk;

  typedef struct {
    int         cyc;
    logic       wf;
    logic       wr;
    logic       er;
    logic       en;
    logic [7:0] data;
  } ev_t;

  ev_t        exp_q[$];
  logic [7:0] fb[$];
  int         total = 0;
  int         bad = 0;
  int         ncyc = 0;
  int         resync_at = -1;
  bit         mon_on = 1'b0;
  logic       prev_en = 1'b0;
  bit         model_en = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h (cycle %0d)", name, act, exp, ncyc);
    end
  endtask

  function automatic void push_ev(int cyc, bit wf, bit wr, bit er, bit e, logic [7:0] d);
    ev_t ev;
    ev.cyc = cyc; ev.wf = wf; ev.wr = wr; ev.er = er; ev.en = e; ev.data = d;
    exp_q.push_back(ev);
  endfunction

  // Frame-level reference: c is the negedge count before the accepting edge,
  // so the first response is observed at negedge c+1.
  function automatic void model_byte(logic [7:0] b, int c);
    logic [7:0] cmd, lo, hi;
    bit ok;
    if (fb.size() == 0 && b != DEF_HEADER) return;
    fb.push_back(b);
    if (fb.size() < FRAME_LEN) return;
    cmd = fb[1]; lo = fb[2]; hi = fb[3];
    ok = 1'b1;
`ifdef TUNE_LOADER_CKSUM_EN
    ok = (fb[4] == (cmd ^ lo ^ hi));
`endif
    fb.delete();
    if (!ok) begin
      push_ev(c + 1, 0, 0, 1, model_en, 8'h00);
    end else if (cmd == DEF_CMD_TUNE) begin
      push_ev(c + 1, 1, 0, 0, 0, lo);
      push_ev(c + 2, 0, 1, 0, 0, hi);
      if (model_en) push_ev(c + 3, 0, 0, 0, 1, 8'h00);
    end else if (cmd == DEF_CMD_RUN) begin
      if (!model_en) push_ev(c + 1, 0, 0, 0, 1, 8'h00);
      model_en = 1'b1;
    end else if (cmd == DEF_CMD_HALT) begin
      if (model_en) push_ev(c + 1, 0, 0, 0, 0, 8'h00);
      model_en = 1'b0;
    end else begin
      push_ev(c + 1, 0, 0, 1, model_en, 8'h00);
    end
  endfunction

  // Monitor: samples on the falling edge, away from the active edge.
  always @(negedge clk) begin
    ev_t e;
    ncyc++;
    if (ncyc == resync_at) begin
      prev_en = en;
      mon_on  = 1'b1;
    end else if (mon_on) begin
      if (!wr_divf && !wr_divr) check("data_idle_zero", data, 0);
      check("strobe_exclusive", wr_divf & wr_divr, 0);
      if (wr_divf || wr_divr || err || (en !== prev_en)) begin
        if (exp_q.size() == 0) begin
          check("unexpected_event", {wr_divf, wr_divr, err, en, data},
                {1'b0, 1'b0, 1'b0, prev_en, 8'h00});
        end else begin
          e = exp_q.pop_front();
          check("ev_cycle", ncyc, e.cyc);
          check("ev_flags", {wr_divf, wr_divr, err, en}, {e.wf, e.wr, e.er, e.en});
          check("ev_data", data, e.data);
        end
      end
      prev_en = en;
    end
  end

  // Stimulus is driven 1 time unit after the rising edge.
  task automatic idle(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic send(input logic [7:0] b);
    int w = 0;
    int c;
    in_valid = 1'b1;
    in_byte  = b;
    while (!in_ready && w < 10) begin @(posedge clk); #1; w++; end
    if (!in_ready) begin
      check("in_ready_wait", in_ready, 1);
      in_valid = 1'b0;
      return;
    end
    @(posedge clk);
    c = ncyc;
    model_byte(b, c);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic send_frame(input logic [7:0] cmd, input logic [7:0] lo,
                            input logic [7:0] hi, input bit cks_bad);
    send(DEF_HEADER);
    send(cmd);
    send(lo);
    send(hi);
`ifdef TUNE_LOADER_CKSUM_EN
    send(cks_bad ? (cmd ^ lo ^ hi ^ 8'h5A) : (cmd ^ lo ^ hi));
`else
    if (cks_bad) idle(1);
`endif
  endtask

  // Reset takes effect on the next rising edge; everything the model expected after it is dropped.
  task automatic do_reset();
    int n;
    rst = 1'b1;
    n = ncyc;
    while (exp_q.size() > 0 && exp_q[exp_q.size()-1].cyc >= n + 2) void'(exp_q.pop_back());
    resync_at = n + 2;
    @(posedge clk); #1;
    rst = 1'b0;
    model_en = 1'b0;
    fb.delete();
    @(negedge clk); #1;
    check("rst_outputs", {wr_divf, wr_divr, err, en, busy, data}, 0);
    check("rst_in_ready", in_ready, 1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1);
  end

  initial begin
    logic [7:0] cmd, lo, hi;
    @(posedge clk); #1;
    do_reset();

    // Tune with en previously 1: en drops for both strobe cycles, then returns.
    send_frame(DEF_CMD_RUN, 8'h00, 8'h00, 0);
    idle(3);
    send_frame(DEF_CMD_TUNE, 8'h34, 8'h12, 0);
    idle(5);

    // Garbage before a RUN frame is dropped silently.
    send_frame(DEF_CMD_HALT, 8'h00, 8'h00, 0);
    idle(3);
    send(8'h00);
    send(8'hFF);
    send_frame(DEF_CMD_RUN, 8'h00, 8'h00, 0);
    idle(3);

    // Unknown command rejected.
    send_frame(8'h07, 8'h00, 8'h00, 0);
    idle(3);

`ifdef TUNE_LOADER_CKSUM_EN
    // Wrong checksum byte 00, then the same frame with cmd^lo^hi = 8'h27.
    send(8'hA5); send(8'h01); send(8'h34); send(8'h12); send(8'h00);
    idle(3);
    send_frame(DEF_CMD_TUNE, 8'h34, 8'h12, 0);
    idle(5);
`endif

    // Stall between LO and HI: busy holds, frame completes.
    send(DEF_HEADER);
    send(DEF_CMD_TUNE);
    send(8'hB7);
    repeat (50) begin
      @(negedge clk);
      check("stall_busy", busy, 1);
    end
    @(posedge clk); #1;
    send(8'h4E);
`ifdef TUNE_LOADER_CKSUM_EN
    send(DEF_CMD_TUNE ^ 8'hB7 ^ 8'h4E);
`endif
    idle(5);

    // HEADER as payload, then reset during WR_F aborts the frame.
    send_frame(DEF_CMD_TUNE, 8'hA5, 8'hC3, 0);
    do_reset();
    idle(5);

    // Reset mid-frame, then a clean frame must still work.
    send(DEF_HEADER);
    send(DEF_CMD_TUNE);
    do_reset();
    send_frame(DEF_CMD_TUNE, 8'h11, 8'h22, 0);
    idle(5);

    // Randomised traffic: garbage, idle gaps, mixed commands, occasional bad checksum.
    for (int f = 0; f < 40; f++) begin
      for (int g = 0; g < int'($urandom_range(0, 2)); g++) send(8'($urandom));
      idle($urandom_range(0, 3));
      case ($urandom_range(0, 3))
        0: cmd = DEF_CMD_TUNE;
        1: cmd = DEF_CMD_RUN;
        2: cmd = DEF_CMD_HALT;
        default: cmd = 8'($urandom);
      endcase
      lo = 8'($urandom);
      hi = 8'($urandom);
      send_frame(cmd, lo, hi, ($urandom_range(0, 4) == 0));
      idle($urandom_range(0, 4));
    end

    idle(10);
    check("scoreboard_drained", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
